// File: rtl/intc_lb_if.sv
// Local-bus register interface for intc_lb: a write channel with byte strobes and a
// single-cycle-latency read channel.
interface intc_lb_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] lb_waddr;
    logic [DATA_W-1:0] lb_wdata;
    logic              lb_wen;
    logic [STRB_W-1:0] lb_wstrb;
    logic              lb_wready;
    logic [ADDR_W-1:0] lb_raddr;
    logic              lb_ren;
    logic [DATA_W-1:0] lb_rdata;
    logic              lb_rvalid;

    modport master (
        output lb_waddr, lb_wdata, lb_wen, lb_wstrb, lb_raddr, lb_ren,
        input  lb_wready, lb_rdata, lb_rvalid
    );

    modport slave (
        input  lb_waddr, lb_wdata, lb_wen, lb_wstrb, lb_raddr, lb_ren,
        output lb_wready, lb_rdata, lb_rvalid
    );
endinterface

// File: rtl/intc_lb.sv
// Interrupt controller: sticky STAT, EN mask, SET, W1C with clear pulses, irq with holdoff.
// Define INTC_EDGE_DETECT_EN to latch status on int_in rising edges instead of levels.
module intc_lb #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CH_N      = 8,
    parameter int unsigned BASE_ADDR = 'h50,
    parameter int unsigned HOLDOFF_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    intc_lb_if.slave        lb,
    input  logic [CH_N-1:0] int_in,
    output logic [CH_N-1:0] int_clr_out,
    output logic            irq_out
);
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [ADDR_W-1:0] AddrStat = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] AddrEn   = ADDR_W'(BASE_ADDR + 32'h4);
    localparam logic [ADDR_W-1:0] AddrPend = ADDR_W'(BASE_ADDR + 32'h8);
    localparam logic [ADDR_W-1:0] AddrSet  = ADDR_W'(BASE_ADDR + 32'hC);
    localparam logic [ADDR_W-1:0] AddrHold = ADDR_W'(BASE_ADDR + 32'h10);

    logic [CH_N-1:0]      stat_q, stat_d;
    logic [CH_N-1:0]      en_q, en_d;
    logic [CH_N-1:0]      clr_q, clr_d;
    logic [HOLDOFF_W-1:0] hold_q, hold_d;
    logic [HOLDOFF_W-1:0] cnt_q, cnt_d;
    logic                 irq_q, irq_d;
    logic                 wready_q;
    logic                 rvalid_q;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    logic [DATA_W-1:0] wmask, wd_m;
    logic              wr_stat, wr_en, wr_set, wr_hold;
    logic [CH_N-1:0]   w1c, sw_set, hw_set, pend;

    always_comb begin
        wmask = '0;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            wmask[b*8 +: 8] = {8{lb.lb_wstrb[b]}};
        end
    end

    assign wd_m    = lb.lb_wdata & wmask;
    assign wr_stat = lb.lb_wen && (lb.lb_waddr == AddrStat);
    assign wr_en   = lb.lb_wen && (lb.lb_waddr == AddrEn);
    assign wr_set  = lb.lb_wen && (lb.lb_waddr == AddrSet);
    assign wr_hold = lb.lb_wen && (lb.lb_waddr == AddrHold);

    assign w1c    = wr_stat ? wd_m[CH_N-1:0] : '0;
    assign sw_set = wr_set ? wd_m[CH_N-1:0] : '0;
    assign pend   = stat_q & en_q;

`ifdef INTC_EDGE_DETECT_EN
    logic [CH_N-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (rst) prev_q <= '0;
        else     prev_q <= int_in;
    end

    assign hw_set = int_in & ~prev_q;
`else
    assign hw_set = int_in;
`endif

    always_comb begin
        // Sets are ORed in after the clear so a simultaneous set wins.
        stat_d = (stat_q & ~w1c) | sw_set | hw_set;
        clr_d  = w1c;
        en_d   = wr_en ? ((en_q & ~wmask[CH_N-1:0]) | wd_m[CH_N-1:0]) : en_q;
        hold_d = wr_hold ? ((hold_q & ~wmask[HOLDOFF_W-1:0]) | wd_m[HOLDOFF_W-1:0]) : hold_q;
        irq_d  = (|pend) && (cnt_q == '0);
        cnt_d  = cnt_q;
        if (irq_q && !irq_d) begin
            cnt_d = hold_q;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - HOLDOFF_W'(1);
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (lb.lb_ren) begin
            case (lb.lb_raddr)
                AddrStat: rdata_d = DATA_W'(stat_q);
                AddrEn:   rdata_d = DATA_W'(en_q);
                AddrPend: rdata_d = DATA_W'(pend);
                AddrHold: rdata_d = DATA_W'(hold_q);
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q   <= '0;
            en_q     <= '0;
            clr_q    <= '0;
            hold_q   <= '0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
            wready_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            stat_q   <= stat_d;
            en_q     <= en_d;
            clr_q    <= clr_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            irq_q    <= irq_d;
            wready_q <= 1'b1;
            rvalid_q <= lb.lb_ren;
            rdata_q  <= rdata_d;
        end
    end

    assign lb.lb_wready = wready_q;
    assign lb.lb_rvalid = rvalid_q;
    assign lb.lb_rdata  = rdata_q;
    assign int_clr_out  = clr_q;
    assign irq_out      = irq_q;

    // Write-data bits beyond the implemented fields are intentionally ignored.
    logic unused_ok;
    assign unused_ok = ^{wd_m, wmask};
endmodule

// File: tb/tb_intc_lb.sv
// Directed self-checking bench for intc_lb (default 8 channels, base 0x50).
module tb_intc_lb;
    localparam logic [15:0] A_STAT = 16'h50;
    localparam logic [15:0] A_EN   = 16'h54;
    localparam logic [15:0] A_PEND = 16'h58;
    localparam logic [15:0] A_SET  = 16'h5C;
    localparam logic [15:0] A_HOLD = 16'h60;
    localparam logic [15:0] A_NONE = 16'h64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] int_in = 8'h00;
    logic [7:0] int_clr_out;
    logic       irq_out;
    int         n_run = 0;
    int         n_fail = 0;

    intc_lb_if #(.ADDR_W(16), .DATA_W(32)) lb ();

    intc_lb dut (
        .clk         (clk),
        .rst         (rst),
        .lb          (lb),
        .int_in      (int_in),
        .int_clr_out (int_clr_out),
        .irq_out     (irq_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_run++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        lb.lb_waddr = a;
        lb.lb_wdata = d;
        lb.lb_wstrb = s;
        lb.lb_wen   = 1'b1;
        tick();
        lb.lb_wen   = 1'b0;
        lb.lb_wstrb = 4'h0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp_v);
        lb.lb_raddr = a;
        lb.lb_ren   = 1'b1;
        tick();
        check({tag, "_rvalid"}, 32'(lb.lb_rvalid), 32'd1);
        check(tag, lb.lb_rdata, exp_v);
        lb.lb_ren = 1'b0;
        tick();
        check({tag, "_rvalid_end"}, 32'(lb.lb_rvalid), 32'd0);
        check({tag, "_hold"}, lb.lb_rdata, exp_v);
    endtask

    initial begin
        lb.lb_waddr = '0;
        lb.lb_wdata = '0;
        lb.lb_wen   = 1'b0;
        lb.lb_wstrb = '0;
        lb.lb_raddr = '0;
        lb.lb_ren   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_wready", 32'(lb.lb_wready), 32'd0);
        check("rst_rvalid", 32'(lb.lb_rvalid), 32'd0);
        check("rst_irq", 32'(irq_out), 32'd0);
        check("rst_clr", 32'(int_clr_out), 32'd0);
        rst = 1'b0;
        tick();
        check("wready_up", 32'(lb.lb_wready), 32'd1);
        rd("rst_stat", A_STAT, 32'h0);
        rd("rst_en", A_EN, 32'h0);
        rd("rst_pend", A_PEND, 32'h0);
        rd("rst_hold", A_HOLD, 32'h0);
        rd("unmapped", A_NONE, 32'h0);

        // Level capture and irq latency
        wr(A_EN, 32'hFF, 4'hF);
        int_in = 8'h03;
        tick();
        int_in = 8'h00;
        check("irq_lat1", 32'(irq_out), 32'd0);
        tick();
        check("irq_lat2", 32'(irq_out), 32'd1);
        rd("stat_03", A_STAT, 32'h03);
        rd("pend_03", A_PEND, 32'h03);

        // W1C and clear pulses
        wr(A_STAT, 32'h01, 4'hF);
        check("clr_pulse0", 32'(int_clr_out), 32'h01);
        tick();
        check("clr_gone0", 32'(int_clr_out), 32'h00);
        rd("stat_02", A_STAT, 32'h02);
        wr(A_STAT, 32'h02, 4'hF);
        check("clr_pulse1", 32'(int_clr_out), 32'h02);
        tick();
        check("irq_fall", 32'(irq_out), 32'd0);
        check("clr_gone1", 32'(int_clr_out), 32'h00);
        rd("stat_00", A_STAT, 32'h0);

        // Holdoff: counter loads 4 on the fall, irq returns once it has drained
        wr(A_HOLD, 32'h4, 4'hF);
        rd("hold_4", A_HOLD, 32'h4);
        wr(A_EN, 32'h01, 4'hF);
        wr(A_SET, 32'h01, 4'hF);
        tick();
        check("ho_irq_up", 32'(irq_out), 32'd1);
        wr(A_STAT, 32'h01, 4'hF);
        check("ho_irq_still", 32'(irq_out), 32'd1);
        wr(A_SET, 32'h01, 4'hF);
        check("ho_fall", 32'(irq_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ho_low", 32'(irq_out), 32'd0);
        end
        tick();
        check("ho_rise", 32'(irq_out), 32'd1);
        wr(A_HOLD, 32'h0, 4'hF);
        wr(A_STAT, 32'h01, 4'hF);
        for (int i = 0; i < 8; i++) tick();
        rd("stat_clean", A_STAT, 32'h0);

        // Set/clear collision on channel 0
        int_in = 8'h01;
        tick();
`ifdef INTC_EDGE_DETECT_EN
        wr(A_STAT, 32'h01, 4'hF);
        check("edge_clr", 32'(int_clr_out), 32'h01);
        tick();
        tick();
        rd("edge_stays0", A_STAT, 32'h0);
        int_in = 8'h00;
        tick();
        int_in = 8'h01;
        tick();
        rd("edge_reset", A_STAT, 32'h01);
        int_in = 8'h00;
`else
        wr(A_STAT, 32'h01, 4'hF);
        check("coll_clr", 32'(int_clr_out), 32'h01);
        int_in = 8'h00;
        rd("coll_stat", A_STAT, 32'h01);
`endif
        wr(A_STAT, 32'h01, 4'hF);
        rd("coll_done", A_STAT, 32'h0);

        // Byte strobes, SET read-back, unmapped write
        wr(A_EN, 32'h0, 4'hF);
        wr(A_EN, 32'hFFFF_FFFF, 4'b0001);
        rd("en_strb1", A_EN, 32'hFF);
        wr(A_EN, 32'h0, 4'b0000);
        rd("en_strb0", A_EN, 32'hFF);
        wr(A_HOLD, 32'hFFFF_ABCD, 4'b0010);
        rd("hold_lane1", A_HOLD, 32'hAB00);
        wr(A_SET, 32'h80, 4'hF);
        rd("set_reads0", A_SET, 32'h0);
        rd("pend_80", A_PEND, 32'h80);
        wr(A_NONE, 32'hFFFF_FFFF, 4'hF);
        rd("unmapped_wr", A_NONE, 32'h0);

        // Mid-operation reset drops the read and the pending clear pulse
        lb.lb_raddr = A_EN;
        lb.lb_ren   = 1'b1;
        lb.lb_waddr = A_STAT;
        lb.lb_wdata = 32'h80;
        lb.lb_wstrb = 4'hF;
        lb.lb_wen   = 1'b1;
        rst         = 1'b1;
        tick();
        lb.lb_ren = 1'b0;
        lb.lb_wen = 1'b0;
        check("mrst_rvalid", 32'(lb.lb_rvalid), 32'd0);
        check("mrst_rdata", lb.lb_rdata, 32'h0);
        check("mrst_clr", 32'(int_clr_out), 32'h0);
        check("mrst_irq", 32'(irq_out), 32'd0);
        check("mrst_wready", 32'(lb.lb_wready), 32'd0);
        rst = 1'b0;
        tick();
        rd("mrst_en", A_EN, 32'h0);
        rd("mrst_hold", A_HOLD, 32'h0);
        rd("mrst_stat", A_STAT, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
